// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: grant source encoding,
// the MDU pending-entry layout and a destination decode helper.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 64;
  localparam int NREGS  = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_MDU  = 2'd2
  } wb_src_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } pend_entry_t;

  function automatic logic [NREGS-1:0] dst_onehot(input logic [REG_W-1:0] dst);
    logic [NREGS-1:0] oh;
    oh      = '0;
    oh[dst] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending FIFO for MDU results. Entries carry a valid bit that a younger
// pipeline write can clear in place (kill-by-dst); cleared entries stay in
// order and are popped by the arbiter without using the write port.
module wb_pend_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_en,
  input  logic [REG_W-1:0]  push_dst,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_en,
  input  logic              kill_en,
  input  logic [REG_W-1:0]  kill_dst,
  output pend_entry_t       head,
  output logic              empty,
  output logic              full,
  output logic [NREGS-1:0]  busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [REG_W-1:0]  dst_q  [DEPTH];
  logic [REG_W-1:0]  dst_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              do_push, do_pop;

  // The extra pointer bit distinguishes full from empty when indices match.
  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign do_push = push_en && !full;
  assign do_pop  = pop_en && !empty;

  assign head.valid = valid_q[rd_idx];
  assign head.dst   = dst_q[rd_idx];
  assign head.data  = data_q[rd_idx];

  // Next state: kill matching stored entries, retire the head, then append.
  // The append lands in a free slot, so a same-cycle push is never killed.
  always_comb begin
    valid_d  = valid_q;
    dst_d    = dst_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (kill_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (dst_q[i] == kill_dst)) begin
          valid_d[i] = 1'b0;
        end
      end
    end
    if (do_pop) begin
      valid_d[rd_idx] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_ONE;
    end
    if (do_push) begin
      valid_d[wr_idx] = 1'b1;
      dst_d[wr_idx]   = push_dst;
      data_d[wr_idx]  = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
  end

  // Busy vector: every live stored entry plus the entry arriving this cycle.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        busy = busy | dst_onehot(dst_q[i]);
      end
    end
    if (do_push) begin
      busy = busy | dst_onehot(push_dst);
    end
  end

  // Control state: pointers and live bits, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage: only meaningful under a live bit, so not reset.
  always_ff @(posedge clk) begin
    dst_q  <= dst_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter between the in-order writeback stage and the
// MDU result path. Grants one source per cycle, kills stale MDU results on
// a younger pipeline write, forces a drain when the MDU side starves, and
// registers the winning write onto the regfile port.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int PEND_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic              wb_wen,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              mdu_valid,
  input  logic [REG_W-1:0]  mdu_dst,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              rf_wen,
  output logic [REG_W-1:0]  rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [NREGS-1:0]  pend_busy
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + 1'b1;
  endfunction

  pend_entry_t       head;
  logic              fifo_empty, fifo_full;
  logic              head_live;
  logic              wb_req_p0;
  wb_src_t           src_p0;
  logic              push_p0, pop_p0, kill_p0;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              vld_p0, vld_p1;
  logic [REG_W-1:0]  wa_p0, wa_p1;
  logic [DATA_W-1:0] wd_p0, wd_p1;

  assign wb_req_p0 = wb_valid && wb_wen && (wb_dst != '0);
  assign head_live = !fifo_empty && head.valid;
  assign mdu_ready = !fifo_full;
  // Results for x0 complete the handshake but never occupy a slot.
  assign push_p0   = mdu_valid && mdu_ready && (mdu_dst != '0);
  assign kill_p0   = (src_p0 == WB_PIPE);
  // Dead heads retire for free; a live head retires only when granted.
  assign pop_p0    = !fifo_empty && (!head.valid || (src_p0 == WB_MDU));

  wb_pend_fifo #(
    .DEPTH(PEND_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_en   (push_p0),
    .push_dst  (mdu_dst),
    .push_data (mdu_data),
    .pop_en    (pop_p0),
    .kill_en   (kill_p0),
    .kill_dst  (wb_dst),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .busy      (pend_busy)
  );

  // Stage p0: priority grant (force drain, full drain, pipeline, idle drain).
  // Uses only state and writeback inputs so wb_stall never sees mdu_valid.
  always_comb begin
    src_p0   = WB_NONE;
    wb_stall = 1'b0;
    if (head_live && (wait_cnt_q == WAIT_MAX)) begin
      src_p0   = WB_MDU;
      wb_stall = wb_req_p0;
    end else if (fifo_full && head_live) begin
      src_p0   = WB_MDU;
      wb_stall = wb_req_p0;
    end else if (wb_req_p0) begin
      src_p0 = WB_PIPE;
    end else if (head_live) begin
      src_p0 = WB_MDU;
    end
  end

  // Stage p0: starvation counter for a live head that keeps losing the port.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((src_p0 == WB_MDU) || fifo_empty) begin
      wait_cnt_d = '0;
    end else if (head_live) begin
      wait_cnt_d = sat_inc(wait_cnt_q);
    end
  end

  // Stage p0: select the winning write for the output register.
  always_comb begin
    vld_p0 = (src_p0 != WB_NONE);
    wa_p0  = wa_p1;
    wd_p0  = wd_p1;
    if (src_p0 == WB_PIPE) begin
      wa_p0 = wb_dst;
      wd_p0 = wb_data;
    end else if (src_p0 == WB_MDU) begin
      wa_p0 = head.dst;
      wd_p0 = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Stage p1: registered regfile write port; data cleared on reset too so the
  // port reads all-zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      wa_p1  <= '0;
      wd_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      wa_p1  <= wa_p0;
      wd_p1  <= wd_p0;
    end
  end

  // A write granted just before reset is dropped rather than issued during it.
  assign rf_wen = vld_p1 && !reset;
  assign rf_wa  = wa_p1;
  assign rf_wd  = wd_p1;

endmodule
